// File: rtl/id_ex_operand_stage_if.sv
// Bundle of decode-side, forwarding-source and EX-side signals for the ID/EX stage.
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 32
);
  // Pipeline control from the hazard unit
  logic                     i_stall;
  logic                     i_flush;
  // Decoded instruction
  logic                     i_id_valid;
  logic [4:0]               i_rs1_addr;
  logic [4:0]               i_rs2_addr;
  logic [4:0]               i_rd_addr;
  logic signed [DATA_W-1:0] i_rs1_data;
  logic signed [DATA_W-1:0] i_rs2_data;
  logic signed [DATA_W-1:0] i_imm;
  logic [3:0]               i_alu_ctrl;
  logic                     i_alu_src;
  logic                     i_reg_write;
  // Forwarding sources
  logic                     i_exmem_reg_write;
  logic [4:0]               i_exmem_rd_addr;
  logic signed [DATA_W-1:0] i_exmem_result;
  logic                     i_memwb_reg_write;
  logic [4:0]               i_memwb_rd_addr;
  logic signed [DATA_W-1:0] i_memwb_result;
  // Execute-stage view
  logic                     o_ex_valid;
  logic signed [DATA_W-1:0] o_alu_in1;
  logic signed [DATA_W-1:0] o_alu_in2;
  logic [3:0]               o_alu_ctrl;
  logic [4:0]               o_rd_addr;
  logic                     o_reg_write;
  logic signed [DATA_W-1:0] o_store_data;

  modport master (
    output i_stall, i_flush, i_id_valid,
    output i_rs1_addr, i_rs2_addr, i_rd_addr,
    output i_rs1_data, i_rs2_data, i_imm,
    output i_alu_ctrl, i_alu_src, i_reg_write,
    output i_exmem_reg_write, i_exmem_rd_addr, i_exmem_result,
    output i_memwb_reg_write, i_memwb_rd_addr, i_memwb_result,
    input  o_ex_valid, o_alu_in1, o_alu_in2, o_alu_ctrl,
    input  o_rd_addr, o_reg_write, o_store_data
  );

  modport slave (
    input  i_stall, i_flush, i_id_valid,
    input  i_rs1_addr, i_rs2_addr, i_rd_addr,
    input  i_rs1_data, i_rs2_data, i_imm,
    input  i_alu_ctrl, i_alu_src, i_reg_write,
    input  i_exmem_reg_write, i_exmem_rd_addr, i_exmem_result,
    input  i_memwb_reg_write, i_memwb_rd_addr, i_memwb_result,
    output o_ex_valid, o_alu_in1, o_alu_in2, o_alu_ctrl,
    output o_rd_addr, o_reg_write, o_store_data
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB.
// Operands are resolved combinationally from the registered specifiers; while
// stalled the held operand data is refreshed from any live forwarding match so
// the value survives after the producer leaves the pipeline.
module id_ex_operand_stage #(
  parameter int DATA_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  id_ex_operand_stage_if.slave bus
);

  logic                     valid_q,     valid_d;
  logic                     reg_write_q, reg_write_d;
  logic                     alu_src_q,   alu_src_d;
  logic [3:0]               alu_ctrl_q,  alu_ctrl_d;
  logic [4:0]               rs1_q,       rs1_d;
  logic [4:0]               rs2_q,       rs2_d;
  logic [4:0]               rd_q,        rd_d;
  logic signed [DATA_W-1:0] rs1_data_q,  rs1_data_d;
  logic signed [DATA_W-1:0] rs2_data_q,  rs2_data_d;
  logic signed [DATA_W-1:0] imm_q,       imm_d;

  logic                     fwd_a_ex, fwd_a_wb, fwd_b_ex, fwd_b_wb;
  logic signed [DATA_W-1:0] op_a, op_b;

  // A producer matches only if it writes, targets this specifier, and the specifier is not x0.
  function automatic logic fwd_hit(input logic we, input logic [4:0] wr, input logic [4:0] rs);
    return we && (wr == rs) && (rs != 5'd0);
  endfunction

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  function automatic logic signed [DATA_W-1:0] fwd_sel(
    input logic                     hit_ex,
    input logic                     hit_wb,
    input logic signed [DATA_W-1:0] ex_val,
    input logic signed [DATA_W-1:0] wb_val,
    input logic signed [DATA_W-1:0] reg_val
  );
    if (hit_ex)      return ex_val;
    else if (hit_wb) return wb_val;
    else             return reg_val;
  endfunction

  // Resolve both operands from the registered specifiers.
  always_comb begin
    fwd_a_ex = fwd_hit(bus.i_exmem_reg_write, bus.i_exmem_rd_addr, rs1_q);
    fwd_a_wb = fwd_hit(bus.i_memwb_reg_write, bus.i_memwb_rd_addr, rs1_q);
    fwd_b_ex = fwd_hit(bus.i_exmem_reg_write, bus.i_exmem_rd_addr, rs2_q);
    fwd_b_wb = fwd_hit(bus.i_memwb_reg_write, bus.i_memwb_rd_addr, rs2_q);
    op_a     = fwd_sel(fwd_a_ex, fwd_a_wb, bus.i_exmem_result, bus.i_memwb_result, rs1_data_q);
    op_b     = fwd_sel(fwd_b_ex, fwd_b_wb, bus.i_exmem_result, bus.i_memwb_result, rs2_data_q);
  end

  // Next-state: flush beats stall; stall holds but refreshes operands; otherwise capture decode.
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    alu_src_d   = alu_src_q;
    alu_ctrl_d  = alu_ctrl_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    if (bus.i_flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      alu_ctrl_d  = 4'b0000;
    end else if (bus.i_stall) begin
      rs1_data_d  = op_a;
      rs2_data_d  = op_b;
    end else begin
      valid_d     = bus.i_id_valid;
      reg_write_d = bus.i_id_valid ? bus.i_reg_write : 1'b0;
      alu_ctrl_d  = bus.i_id_valid ? bus.i_alu_ctrl  : 4'b0000;
      alu_src_d   = bus.i_alu_src;
      rs1_d       = bus.i_rs1_addr;
      rs2_d       = bus.i_rs2_addr;
      rd_d        = bus.i_rd_addr;
      rs1_data_d  = bus.i_rs1_data;
      rs2_data_d  = bus.i_rs2_data;
      imm_d       = bus.i_imm;
    end
  end

  // Pipeline register; reset clears everything asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      alu_src_q   <= 1'b0;
      alu_ctrl_q  <= 4'b0000;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      rd_q        <= 5'd0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      alu_src_q   <= alu_src_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
    end
  end

  // The ALU computes in2 - in1, so rs1 goes to in2 and rs2/imm to in1.
  assign bus.o_alu_in2    = op_a;
  assign bus.o_alu_in1    = alu_src_q ? imm_q : op_b;
  assign bus.o_store_data = op_b;
  assign bus.o_ex_valid   = valid_q;
  assign bus.o_reg_write  = reg_write_q & valid_q;
  assign bus.o_alu_ctrl   = alu_ctrl_q;
  assign bus.o_rd_addr    = rd_q;

endmodule
